// File: rtl/bus_pkg.sv
// bus_pkg: shared state encoding and index-width helper for the bus transfer controller.
package bus_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, LOAD} xfer_state_t;
  // One spare code beyond NSRC-1 so out-of-range source requests can be encoded and rejected
  function automatic int src_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/bus_src_mux.sv
// bus_src_mux: NSRC:1 bus source select; drives 0 when disabled or index out of range.
module bus_src_mux import bus_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int NSRC  = 4,
  parameter int SW    = src_w(NSRC)
) (
  input  logic                  en_i,
  input  logic [SW-1:0]         sel_i,
  input  logic [NSRC*WIDTH-1:0] src_dat_i,
  output logic [WIDTH-1:0]      dat_o
);
  always_comb begin
    dat_o = '0;
    for (int k = 0; k < NSRC; k++)
      if (en_i && sel_i == SW'(k)) dat_o = src_dat_i[k*WIDTH +: WIDTH];
  end
endmodule

// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: drives the shared bus from one source and pulses destination WENs (settle then load).
// Define BUS_XFER_BYPASS_EN to drop the settle cycle (accept goes straight to LOAD).
module bus_xfer_ctrl import bus_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int NSRC  = 4,
  parameter int NDST  = 4,
  parameter int SW    = src_w(NSRC)
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [SW-1:0]         req_src,
  input  logic [NDST-1:0]       req_dst_mask,
  input  logic [NSRC*WIDTH-1:0] src_dat,
  output logic [WIDTH-1:0]      bus_dat,
  output logic [NDST-1:0]       dst_wen,
  output logic                  done,
  output logic                  err
);
`ifdef BUS_XFER_BYPASS_EN
  localparam xfer_state_t GO = LOAD;
`else
  localparam xfer_state_t GO = DRIVE;
`endif
  xfer_state_t state_q, state_d;
  logic [SW-1:0] src_q;
  logic [NDST-1:0] mask_q;
  logic err_q, acc, bad;
  assign acc = req_valid & req_ready;
  assign bad = ~|req_dst_mask || req_src >= SW'(NSRC);
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state_q <= IDLE;
      src_q   <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= acc & bad;
      if (acc) begin
        src_q  <= req_src;
        mask_q <= req_dst_mask;
      end
    end
  // DRIVE never accepts, so only IDLE/LOAD can launch a new transfer
  always_comb
    state_d = state_q == DRIVE ? LOAD : (acc && !bad) ? GO : IDLE;
  always_comb begin
    req_ready = state_q != DRIVE;
    dst_wen   = state_q == LOAD ? mask_q : '0;
    done      = state_q == LOAD;
    err       = err_q;
  end
  bus_src_mux #(.WIDTH(WIDTH), .NSRC(NSRC), .SW(SW)) u_mux (
    .en_i      (state_q != IDLE),
    .sel_i     (src_q),
    .src_dat_i (src_dat),
    .dat_o     (bus_dat)
  );
endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb_bus_xfer_ctrl: table-driven cycle vectors plus hand-written reset and bypass sequences.
module tb_bus_xfer_ctrl;
  typedef struct {
    logic v; logic [2:0] s; logic [3:0] m; logic [31:0] d;
    logic [7:0] bus; logic [3:0] wen; logic done, err, rdy;
  } vec_t;
  localparam logic [31:0] D  = 32'h3CA55A11;
  localparam logic [31:0] D2 = 32'h3CA57711;
  logic CLK = 1'b0, nRST = 1'b0, req_valid = 1'b0, req_ready, done, err;
  logic [2:0] req_src = '0;
  logic [3:0] req_dst_mask = '0, dst_wen;
  logic [31:0] src_dat = D;
  logic [7:0] bus_dat;
  int total = 0, bad = 0;
  vec_t tv[$];
  always #5 CLK = ~CLK;
  bus_xfer_ctrl dut (
    .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst_mask(req_dst_mask), .src_dat(src_dat),
    .bus_dat(bus_dat), .dst_wen(dst_wen), .done(done), .err(err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic add(input logic v, input logic [2:0] s, input logic [3:0] m, input logic [31:0] d,
                     input logic [7:0] b, input logic [3:0] w, input logic dn, input logic e, input logic r);
    vec_t x;
    x.v = v; x.s = s; x.m = m; x.d = d; x.bus = b; x.wen = w; x.done = dn; x.err = e; x.rdy = r;
    tv.push_back(x);
  endtask
  task automatic drive(input logic v, input logic [2:0] s, input logic [3:0] m);
    @(posedge CLK);
    #1;
    req_valid = v; req_src = s; req_dst_mask = m;
  endtask
  initial begin
    #12;
    chk("rst_bus", bus_dat, 0);
    chk("rst_wen", dst_wen, 0);
    chk("rst_rdy", req_ready, 1);
    chk("rst_err", err, 0);
    #5 nRST = 1'b1;
`ifndef BUS_XFER_BYPASS_EN
    for (int i = 0; i < 5; i++) add(0, 0, 0, D, 8'h00, 0, 0, 0, 1);
    add(1, 2, 4'b0010, D, 8'h00, 0, 0, 0, 1);
    add(0, 0, 0, D, 8'hA5, 0, 0, 0, 0);
    add(0, 0, 0, D, 8'hA5, 4'b0010, 1, 0, 1);
    add(0, 0, 0, D, 8'h00, 0, 0, 0, 1);
    add(1, 0, 4'b0001, D, 8'h00, 0, 0, 0, 1);
    add(1, 3, 4'b1100, D, 8'h11, 0, 0, 0, 0);
    add(1, 3, 4'b1100, D, 8'h11, 4'b0001, 1, 0, 1);
    add(0, 0, 0, D, 8'h3C, 0, 0, 0, 0);
    add(0, 0, 0, D, 8'h3C, 4'b1100, 1, 0, 1);
    add(0, 0, 0, D, 8'h00, 0, 0, 0, 1);
    add(1, 1, 4'b0000, D, 8'h00, 0, 0, 0, 1);
    add(0, 0, 0, D, 8'h00, 0, 0, 1, 1);
    add(1, 4, 4'b0001, D, 8'h00, 0, 0, 0, 1);
    add(0, 0, 0, D, 8'h00, 0, 0, 1, 1);
    add(0, 0, 0, D, 8'h00, 0, 0, 0, 1);
    add(1, 1, 4'b1111, D, 8'h00, 0, 0, 0, 1);
    add(0, 0, 0, D2, 8'h77, 0, 0, 0, 0);
    add(0, 0, 0, D2, 8'h77, 4'b1111, 1, 0, 1);
    add(0, 0, 0, D, 8'h00, 0, 0, 0, 1);
    foreach (tv[i]) begin
      drive(tv[i].v, tv[i].s, tv[i].m);
      src_dat = tv[i].d;
      @(negedge CLK);
      chk($sformatf("v%0d_bus", i), bus_dat, tv[i].bus);
      chk($sformatf("v%0d_wen", i), dst_wen, tv[i].wen);
      chk($sformatf("v%0d_done", i), done, tv[i].done);
      chk($sformatf("v%0d_err", i), err, tv[i].err);
      chk($sformatf("v%0d_rdy", i), req_ready, tv[i].rdy);
    end
    drive(1, 2, 4'b0001);
    drive(0, 0, 0);
    @(negedge CLK);
    chk("abort_drive_bus", bus_dat, 8'hA5);
    #2 nRST = 1'b0;
    #1;
    chk("abort_bus", bus_dat, 0);
    chk("abort_wen", dst_wen, 0);
    chk("abort_rdy", req_ready, 1);
    chk("abort_done", done, 0);
    #1 nRST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk($sformatf("abort_after%0d_wen", i), dst_wen, 0);
      chk($sformatf("abort_after%0d_bus", i), bus_dat, 0);
    end
`else
    drive(1, 1, 4'b1000);
    @(negedge CLK);
    chk("byp_rdy", req_ready, 1);
    drive(0, 0, 0);
    @(negedge CLK);
    chk("byp_wen", dst_wen, 4'b1000);
    chk("byp_bus", bus_dat, 8'h5A);
    chk("byp_done", done, 1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 3'(i), 4'(1 << i));
      @(negedge CLK);
      chk($sformatf("burst%0d_rdy", i), req_ready, 1);
      chk($sformatf("burst%0d_wen", i), dst_wen, i == 0 ? 0 : 1 << (i - 1));
    end
    drive(0, 0, 0);
    @(negedge CLK);
    chk("burst_last_wen", dst_wen, 4'b1000);
    chk("burst_last_bus", bus_dat, 8'h3C);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
